// File: rtl/alu_muldiv_if.sv
// rtl/alu_muldiv_if.sv - request/response bundle for the multi-cycle multiply/divide unit
// Signals:
//   start      request, sampled only when the unit is idle
//   op         0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   operand_a  rs1 (multiplicand / dividend), captured at acceptance
//   operand_b  rs2 (multiplier / divisor), captured at acceptance
//   flush      abort any in-flight operation
//   busy       unit is not idle; pipeline must stall
//   done       one-cycle pulse, result valid
//   result     last result, held until the next done
//   zero       result == 0, updated together with result
interface alu_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output start, op, operand_a, operand_b, flush,
        input  busy, done, result, zero
    );

    modport slave (
        input  start, op, operand_a, operand_b, flush,
        output busy, done, result, zero
    );
endinterface

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative RV32M multiply/divide unit (shift-add multiplier, restoring divider)
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   alu_muldiv_if slave: start/op/operand_a/operand_b/flush in, busy/done/result/zero out
// Operands are reduced to magnitudes at acceptance, XLEN unsigned steps run in CALC,
// and the sign of the result is restored in FIX.
module alu_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    alu_muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]      op_r;
    logic            neg_res;   // product / quotient must be negated
    logic            neg_rem;   // remainder takes the dividend's sign
    logic [XLEN-1:0] hi;        // product high half / partial remainder
    logic [XLEN-1:0] lo;        // multiplier bits (shifted out) / dividend bits -> quotient
    logic [XLEN-1:0] b_r;       // multiplicand / divisor magnitude
    logic            done_r;
    logic [XLEN-1:0] result_r;
    logic            zero_r;

    // Acceptance-time decode on the live inputs
    logic            a_signed, b_signed, sa, sb;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] special_res;

    always_comb begin
        a_signed    = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
        b_signed    = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
        sa          = a_signed & bus.operand_a[XLEN-1];
        sb          = b_signed & bus.operand_b[XLEN-1];
        mag_a       = sa ? -bus.operand_a : bus.operand_a;
        mag_b       = sb ? -bus.operand_b : bus.operand_b;
        div_zero    = bus.op[2] && (bus.operand_b == '0);
        div_ovf     = ((bus.op == 3'd4) || (bus.op == 3'd6)) &&
                      (bus.operand_a == MIN_INT) && (bus.operand_b == '1);
        // op[1] separates REM/REMU from DIV/DIVU
        if (div_zero)
            special_res = bus.op[1] ? bus.operand_a : '1;
        else
            special_res = bus.op[1] ? '0 : bus.operand_a;
    end

    // One iteration step for either datapath
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_sh;
    logic [XLEN:0]   div_diff;

    always_comb begin
        mul_sum  = {1'b0, hi} + {1'b0, (lo[0] ? b_r : '0)};
        div_sh   = {hi, lo[XLEN-1]};
        div_diff = div_sh - {1'b0, b_r};   // bit XLEN set means the trial subtraction underflowed
    end

    // Sign correction and half selection
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod_fix = neg_res ? -{hi, lo} : {hi, lo};
        case (op_r)
            3'd0:             fix_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:       fix_res = neg_res ? -lo : lo;
            default:          fix_res = neg_rem ? -hi : hi;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_r     <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            b_r      <= '0;
            done_r   <= 1'b0;
            result_r <= '0;
            zero_r   <= 1'b1;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        op_r    <= bus.op;
                        neg_res <= sa ^ sb;
                        neg_rem <= sa;
                        hi      <= '0;
                        lo      <= mag_a;
                        b_r     <= mag_b;
                        cnt     <= CNT_W'(XLEN);
                        if (div_zero || div_ovf) begin
                            result_r <= special_res;
                            zero_r   <= (special_res == '0);
                            done_r   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        if (op_r[2]) begin
                            if (!div_diff[XLEN]) begin
                                hi <= div_diff[XLEN-1:0];
                                lo <= {lo[XLEN-2:0], 1'b1};
                            end else begin
                                hi <= div_sh[XLEN-1:0];
                                lo <= {lo[XLEN-2:0], 1'b0};
                            end
                        end else begin
                            hi <= mul_sum[XLEN:1];
                            lo <= {mul_sum[0], lo[XLEN-1:1]};
                        end
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1))
                            state <= FIX;
                    end
                end
                FIX: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        result_r <= fix_res;
                        zero_r   <= (fix_res == '0);
                        done_r   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.zero   = zero_r;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - self-checking bench for alu_muldiv
module tb_alu_muldiv;
    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   done_seen = 0;
    int   exp_done = 0;

    alu_muldiv_if #(.XLEN(32)) bus ();

    alu_muldiv #(.XLEN(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done === 1'b1) done_seen++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return MIN_INT;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && b == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == MIN_INT && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return MIN_INT;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 15);
            4: return -$urandom_range(1, 15);
            default: return $urandom;
        endcase
    endfunction

    // Issue one operation, scramble the operands after acceptance, and wait for done
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic zf, output int lat);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.operand_a = a; bus.operand_b = b;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'($urandom); bus.operand_a = $urandom; bus.operand_b = $urandom;
        exp_done++;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = bus.result;
        zf  = bus.zero;
    endtask

    typedef struct {
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } dir_t;

    dir_t dirs[12] = '{
        '{3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34},
        '{3'd1, MIN_INT,      MIN_INT,       32'h4000_0000, 34},
        '{3'd3, MIN_INT,      MIN_INT,       32'h4000_0000, 34},
        '{3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 34},
        '{3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34},
        '{3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34},
        '{3'd5, 32'd100,      32'd7,         32'd14,        34},
        '{3'd7, 32'd100,      32'd7,         32'd2,         34},
        '{3'd5, 32'd5,        32'd0,         32'hFFFF_FFFF, 1},
        '{3'd6, 32'd5,        32'd0,         32'd5,         1},
        '{3'd4, MIN_INT,      32'hFFFF_FFFF, MIN_INT,       1},
        '{3'd6, MIN_INT,      32'hFFFF_FFFF, 32'd0,         1}
    };

    initial begin
        logic [31:0] res, prev, a, b;
        logic        zf;
        logic [2:0]  o;
        int          lat;

        bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0; bus.operand_a = '0; bus.operand_b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_result", bus.result, 0);
        check("reset_zero", bus.zero, 1);
        rst = 1'b0;

        foreach (dirs[i]) begin
            do_op(dirs[i].o, dirs[i].a, dirs[i].b, res, zf, lat);
            check($sformatf("dir%0d_result", i), res, dirs[i].exp);
            check($sformatf("dir%0d_zero", i), zf, dirs[i].exp == 0);
            check($sformatf("dir%0d_latency", i), lat, dirs[i].lat);
        end

        // Start while busy is ignored; flush aborts without a done and keeps the old result
        prev = bus.result;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd4; bus.operand_a = 32'd1000; bus.operand_b = 32'd3;
        @(negedge clk);                      // cycle 1
        bus.start = 1'b0;
        repeat (4) @(negedge clk);           // cycle 5
        bus.start = 1'b1; bus.op = 3'd0;
        check("busy_at_restart", bus.busy, 1);
        @(negedge clk);                      // cycle 6
        bus.start = 1'b0;
        repeat (4) @(negedge clk);           // cycle 10
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", bus.busy, 0);
        check("flush_done", bus.done, 0);
        check("flush_result", bus.result, prev);
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, res, zf, lat);
        check("after_flush_result", res, 32'hFFFF_FFEB);
        check("after_flush_latency", lat, 34);

        // flush together with start in IDLE: nothing is accepted
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd0;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        check("flush_start_idle_busy", bus.busy, 0);

        // flush during the done cycle: done still visible, unit back to IDLE
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd5; bus.operand_a = 32'd9; bus.operand_b = 32'd0;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b1;
        exp_done++;
        check("flush_in_done_done", bus.done, 1);
        check("flush_in_done_result", bus.result, 32'hFFFF_FFFF);
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_in_done_idle", bus.busy, 0);

        // Reset mid-MULHU
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd3; bus.operand_a = 32'hDEAD_BEEF; bus.operand_b = 32'h1234_5678;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);          // cycle 20
        check("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_zero", bus.zero, 1);
        @(negedge clk);
        rst = 1'b0;

        // Random operations against the reference model
        for (int n = 0; n < 1500; n++) begin
            o = 3'($urandom);
            a = pick();
            b = pick();
            do_op(o, a, b, res, zf, lat);
            check($sformatf("rnd%0d_op%0d_result", n, o), res, ref_op(o, a, b));
            check($sformatf("rnd%0d_op%0d_zero", n, o), zf, ref_op(o, a, b) == 0);
            check($sformatf("rnd%0d_op%0d_latency", n, o), lat, ref_lat(o, a, b));
        end

        repeat (3) @(negedge clk);
        check("done_count", done_seen, exp_done);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
